// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo
//   AXI-Stream byte FIFO feeding the AXIS-to-UART transmitter. It absorbs host
//   bursts and carries tlast alongside each word. In packet mode, words are only
//   offered downstream once a complete packet (a stored tlast) is present, or
//   once the FIFO is full, so that an oversize packet cannot deadlock.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   s_axis_*        write side: data/valid/last in, ready out (= !full)
//   m_axis_*        read side: data/valid/last out, ready in
//   level           words currently stored (0..DEPTH)
//   pkt_count       tlast-marked words currently stored
module axis_pkt_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 4,
  parameter bit          PKT_MODE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_axis_data,
  input  logic                 s_axis_valid,
  input  logic                 s_axis_last,
  output logic                 s_axis_ready,
  output logic [DATA_BITS-1:0] m_axis_data,
  output logic                 m_axis_valid,
  output logic                 m_axis_last,
  input  logic                 m_axis_ready,
  output logic [ADDR_BITS:0]   level,
  output logic [ADDR_BITS:0]   pkt_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  // Storage: {last, data}; intentionally not reset.
  logic [DATA_BITS:0] r_mem [DEPTH];

  logic [ADDR_BITS:0] r_wr_ptr;
  logic [ADDR_BITS:0] r_rd_ptr;
  logic [ADDR_BITS:0] r_level;
  logic [ADDR_BITS:0] r_pkt_count;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic               w_push_last;
  logic               w_pop_last;
  logic [DATA_BITS:0] w_head;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_BITS] != r_rd_ptr[ADDR_BITS]) &&
                   (r_wr_ptr[ADDR_BITS-1:0] == r_rd_ptr[ADDR_BITS-1:0]);

  always_comb begin
    w_valid = !w_empty;
    if (PKT_MODE) begin
      // Full term releases a packet longer than the FIFO in cut-through fashion.
      w_valid = !w_empty && ((r_pkt_count != '0) || w_full);
    end
  end

  assign w_head      = r_mem[r_rd_ptr[ADDR_BITS-1:0]];
  assign w_push      = s_axis_valid && !w_full;
  assign w_pop       = w_valid && m_axis_ready;
  assign w_push_last = w_push && s_axis_last;
  assign w_pop_last  = w_pop && w_head[DATA_BITS];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= {s_axis_last, s_axis_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + CNT_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + CNT_ONE;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - CNT_ONE;
      end
      if (w_push_last && !w_pop_last) begin
        r_pkt_count <= r_pkt_count + CNT_ONE;
      end else if (w_pop_last && !w_push_last) begin
        r_pkt_count <= r_pkt_count - CNT_ONE;
      end
    end
  end

  assign s_axis_ready = !w_full;
  assign m_axis_valid = w_valid;
  assign m_axis_data  = w_valid ? w_head[DATA_BITS-1:0] : '0;
  assign m_axis_last  = w_valid && w_head[DATA_BITS];
  assign level        = r_level;
  assign pkt_count    = r_pkt_count;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: one cut-through and one packet-mode instance share
// the same stimulus; each is compared every cycle against a list-of-words model.
module tb_axis_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sd;
  logic       sv;
  logic       sl;
  logic       mr;

  logic       sr  [2];
  logic       mv  [2];
  logic       ml  [2];
  logic [7:0] md  [2];
  logic [4:0] lvl [2];
  logic [4:0] pc  [2];

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_BITS(8), .ADDR_BITS(4), .PKT_MODE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_axis_data(sd), .s_axis_valid(sv), .s_axis_last(sl), .s_axis_ready(sr[0]),
    .m_axis_data(md[0]), .m_axis_valid(mv[0]), .m_axis_last(ml[0]), .m_axis_ready(mr),
    .level(lvl[0]), .pkt_count(pc[0])
  );

  axis_pkt_fifo #(.DATA_BITS(8), .ADDR_BITS(4), .PKT_MODE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_axis_data(sd), .s_axis_valid(sv), .s_axis_last(sl), .s_axis_ready(sr[1]),
    .m_axis_data(md[1]), .m_axis_valid(mv[1]), .m_axis_last(ml[1]), .m_axis_ready(mr),
    .level(lvl[1]), .pkt_count(pc[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: ordered list of stored {last,data} words per instance.
  logic [8:0] mq  [2][17];
  int         cnt [2];

  typedef struct {
    logic       sv;
    logic       sl;
    logic [7:0] sd;
    logic       mr;
    logic       e_sr;
    logic       e_mv;
    logic       e_ml;
    logic [7:0] e_md;
    logic [4:0] e_lvl;
    logic [4:0] e_pc;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    for (int m = 0; m < 2; m++) begin
      int         pcnt;
      bit         full;
      bit         valid;
      bit         push;
      bit         pop;
      logic [8:0] head;
      pcnt = 0;
      for (int k = 0; k < cnt[m]; k++) if (mq[m][k][8]) pcnt++;
      full  = (cnt[m] == 16);
      valid = (cnt[m] != 0) && ((m == 0) || (pcnt != 0) || full);
      head  = valid ? mq[m][0] : 9'h0;
      chk($sformatf("m%0d_ready", m), 32'(sr[m]), 32'(!full));
      chk($sformatf("m%0d_valid", m), 32'(mv[m]), 32'(valid));
      chk($sformatf("m%0d_data", m), 32'(md[m]), 32'(head[7:0]));
      chk($sformatf("m%0d_last", m), 32'(ml[m]), 32'(head[8]));
      chk($sformatf("m%0d_level", m), 32'(lvl[m]), 32'(cnt[m]));
      chk($sformatf("m%0d_pkts", m), 32'(pc[m]), 32'(pcnt));
      push = sv && !full;
      pop  = valid && mr;
      if (pop) begin
        for (int k = 0; k < cnt[m] - 1; k++) mq[m][k] = mq[m][k+1];
        cnt[m]--;
      end
      if (push) begin
        mq[m][cnt[m]] = {sl, sd};
        cnt[m]++;
      end
    end
  endtask

  task automatic pre();
    @(negedge clk);
  endtask

  task automatic post();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sv  = 1'b0;
    sl  = 1'b0;
    sd  = 8'h00;
    mr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
  endtask

  task automatic push_word(input logic [7:0] d, input logic l);
    sv = 1'b1;
    sd = d;
    sl = l;
    step();
    sv = 1'b0;
    sl = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sv = 1'b0; sl = 1'b0; sd = 8'h00; mr = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;

    //           sv    sl    sd     mr    sr    mv    ml    md     lvl   pc
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 5'd0};
    tbl[1] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 5'd0};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd1, 5'd1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd1, 5'd1};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 5'd0};
    tbl[5] = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 5'd0};
    tbl[6] = '{1'b1, 1'b1, 8'h4D, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 5'd1, 5'd0};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h4D, 5'd1, 5'd1};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 5'd0};

    do_reset();

    // Cut-through vectors.
    for (int i = 0; i < 9; i++) begin
      sv = tbl[i].sv; sl = tbl[i].sl; sd = tbl[i].sd; mr = tbl[i].mr;
      pre();
      chk($sformatf("tbl%0d_ready", i), 32'(sr[0]), 32'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_valid", i), 32'(mv[0]), 32'(tbl[i].e_mv));
      chk($sformatf("tbl%0d_last", i), 32'(ml[0]), 32'(tbl[i].e_ml));
      chk($sformatf("tbl%0d_data", i), 32'(md[0]), 32'(tbl[i].e_md));
      chk($sformatf("tbl%0d_level", i), 32'(lvl[0]), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_pkts", i), 32'(pc[0]), 32'(tbl[i].e_pc));
      post();
    end
    sv = 1'b0; sl = 1'b0; mr = 1'b0;

    // Fill / overflow attempt / drain, twice so the pointers wrap.
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      mr = 1'b0;
      for (int i = 0; i < 16; i++) push_word(8'(i), 1'b0);
      sv = 1'b1; sd = 8'h10; sl = 1'b0;
      pre();
      chk("full_ready", 32'(sr[0]), 32'd0);
      chk("full_level", 32'(lvl[0]), 32'd16);
      post();
      sv = 1'b0;
      pre();
      chk("full_level_after_reject", 32'(lvl[0]), 32'd16);
      post();
      mr = 1'b1;
      for (int i = 0; i < 16; i++) begin
        pre();
        chk($sformatf("drain%0d_valid", i), 32'(mv[0]), 32'd1);
        chk($sformatf("drain%0d_data", i), 32'(md[0]), 32'(i));
        if (pass == 0 && i == 0) begin
          chk("pkt_full_release_valid", 32'(mv[1]), 32'd1);
          chk("pkt_full_release_data", 32'(md[1]), 32'h00);
        end
        post();
      end
      mr = 1'b0;
      pre();
      chk("drained_valid", 32'(mv[0]), 32'd0);
      post();
    end

    // Store-and-forward: nothing offered until tlast is stored.
    do_reset();
    push_word(8'h11, 1'b0);
    push_word(8'h22, 1'b0);
    sv = 1'b1; sd = 8'h33; sl = 1'b1;
    pre();
    chk("pkt_hold_valid", 32'(mv[1]), 32'd0);
    post();
    sv = 1'b0; sl = 1'b0;
    pre();
    chk("pkt_release_valid", 32'(mv[1]), 32'd1);
    chk("pkt_release_count", 32'(pc[1]), 32'd1);
    post();
    mr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pre();
      chk($sformatf("pkt_pop%0d_data", i), 32'(md[1]), 32'(8'h11 * (i + 1)));
      chk($sformatf("pkt_pop%0d_last", i), 32'(ml[1]), 32'(i == 2));
      post();
    end
    pre();
    chk("pkt_empty_valid", 32'(mv[1]), 32'd0);
    post();
    mr = 1'b0;

    // Simultaneous push and pop at level 5.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'(8'h50 + i), 1'b0);
    mr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sv = 1'b1; sd = 8'(8'h60 + i); sl = 1'b0;
      pre();
      chk($sformatf("pp%0d_level", i), 32'(lvl[0]), 32'd5);
      chk($sformatf("pp%0d_data", i), 32'(md[0]), 32'(8'h50 + i));
      post();
    end
    sv = 1'b0; mr = 1'b0;
    step();

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    chk("async_level0", 32'(lvl[0]), 32'd0);
    chk("async_valid0", 32'(mv[0]), 32'd0);
    chk("async_level1", 32'(lvl[1]), 32'd0);
    chk("async_ready1", 32'(sr[1]), 32'd1);
    do_reset();
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sv = ($urandom_range(0, 3) != 0);
      sl = ($urandom_range(0, 3) == 0);
      sd = 8'($urandom);
      if ((i / 200) % 2 == 0) mr = ($urandom_range(0, 3) == 0);
      else mr = ($urandom_range(0, 3) != 0);
      step();
    end
    sv = 1'b0; mr = 1'b1;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
